rs_pulse_conditioner: RTL and testbench

//  Upstream front-end for the synchronous RS trigger. Takes two raw, asynchronous, bouncy

---
 rtl/rs_pulse_conditioner_pkg.sv | 21 ++
 rtl/rs_debounce_channel.sv | 47 ++++
 rtl/rs_pulse_conditioner.sv | 99 +++++++++
 tb/tb_rs_pulse_conditioner.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pulse_conditioner_pkg.sv
// Shared types and helpers for the RS trigger pulse conditioner.
// Holds the FSM state encoding, the drop counter width and a saturating adder.
package rs_pulse_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET_P = 2'd1,
        RST_P = 2'd2
    } state_t;

    localparam int DROP_CNT_W = 8;

    // Adds 0..2 dropped requests and clamps at all-ones instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_add(input logic [DROP_CNT_W-1:0] a,
                                                      input logic [1:0] inc);
        logic [DROP_CNT_W:0] sum;
        sum = {1'b0, a} + {{(DROP_CNT_W-1){1'b0}}, inc};
        return sum[DROP_CNT_W] ? '1 : sum[DROP_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/rs_debounce_channel.sv
// One request line: 2-flop synchroniser, stable-sample debouncer and rising-edge detector.
module rs_debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES > 2 ? DEBOUNCE_CYCLES : 2);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          lvl_d;
    logic [CW-1:0] cnt;

    // The level only follows sync2 after it has differed for DEBOUNCE_CYCLES samples in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            lvl   <= 1'b0;
            lvl_d <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            lvl_d <= lvl;
            if (sync2 != lvl) begin
                if (cnt == CNT_MAX) begin
                    lvl <= sync2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign rise = lvl & ~lvl_d;

endmodule

// File: rtl/rs_pulse_conditioner.sv
// Turns two raw bouncy request lines into clean, mutually exclusive one-shot S/R pulses.
module rs_pulse_conditioner
    import rs_pulse_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_LEN       = 1,
    parameter bit RST_PRIORITY    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_in,
    input  logic                  reset_in,
    output logic                  S,
    output logic                  R,
    output logic                  busy,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int PW = $clog2(PULSE_LEN > 2 ? PULSE_LEN : 2);
    localparam logic [PW-1:0] PLEN_MAX = PW'(PULSE_LEN - 1);

    logic   set_lvl;
    logic   set_rise;
    logic   rst_lvl;
    logic   rst_rise;
    state_t state;
    logic [PW-1:0] plen;

    rs_debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_chan (
        .clk  (clk),
        .rst  (rst),
        .din  (set_in),
        .lvl  (set_lvl),
        .rise (set_rise)
    );

    rs_debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst_chan (
        .clk  (clk),
        .rst  (rst),
        .din  (reset_in),
        .lvl  (rst_lvl),
        .rise (rst_rise)
    );

    // Outputs are loaded together with the next state so S/R appear the cycle the state is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            plen     <= '0;
            S        <= 1'b0;
            R        <= 1'b0;
            busy     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    plen <= '0;
                    if (set_rise && rst_rise) begin
                        drop_cnt <= sat_add(drop_cnt, 2'd1);
                        if (RST_PRIORITY) begin
                            state <= RST_P;
                            R     <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end else if (set_rise) begin
                        state <= SET_P;
                        S     <= 1'b1;
                        busy  <= 1'b1;
                    end else if (rst_rise) begin
                        state <= RST_P;
                        R     <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                SET_P, RST_P: begin
                    // Requests arriving mid-pulse are discarded rather than queued.
                    drop_cnt <= sat_add(drop_cnt, {1'b0, set_rise} + {1'b0, rst_rise});
                    if (plen == PLEN_MAX) begin
                        state <= IDLE;
                        plen  <= '0;
                        S     <= 1'b0;
                        R     <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        plen <= plen + PW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    plen  <= '0;
                    S     <= 1'b0;
                    R     <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_pulse_conditioner.sv
// Directed bench for rs_pulse_conditioner; two instances cover both conflict policies.
module tb_rs_pulse_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       setIn = 1'b0;
    logic       resetIn = 1'b0;
    logic       s1, r1, busy1;
    logic       s0, r0, busy0;
    logic [7:0] drop1, drop0;
    int         assertCount = 0;
    int         failCount = 0;

    rs_pulse_conditioner #(.DEBOUNCE_CYCLES(4), .PULSE_LEN(2), .RST_PRIORITY(1'b1)) dutP1 (
        .clk(clk), .rst(rst), .set_in(setIn), .reset_in(resetIn),
        .S(s1), .R(r1), .busy(busy1), .drop_cnt(drop1)
    );

    rs_pulse_conditioner #(.DEBOUNCE_CYCLES(4), .PULSE_LEN(2), .RST_PRIORITY(1'b0)) dutP0 (
        .clk(clk), .rst(rst), .set_in(setIn), .reset_in(resetIn),
        .S(s0), .R(r0), .busy(busy0), .drop_cnt(drop0)
    );

    always #5 clk = ~clk;

    // S and R must never be high together on either instance.
    always @(negedge clk) begin
        assertCount++;
        if ((s1 && r1) || (s0 && r0)) begin
            failCount++;
            $display("[TB] FAIL exclusive_sr: got S1=%b R1=%b S0=%b R0=%b required no S&&R", s1, r1, s0, r0);
        end
    end

    task automatic doReset();
        rst = 1'b1;
        setIn = 1'b0;
        resetIn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1;
            setIn = ~setIn;
            resetIn = ~resetIn;
            assertCount++;
            if ({s1, r1, busy1, s0, r0, busy0} !== 6'b0 || drop1 !== 8'd0 || drop0 !== 8'd0) begin
                failCount++;
                $display("[TB] FAIL reset_state n=%0d: got S/R/busy=%b%b%b %b%b%b drop=%0d/%0d required all 0",
                         n, s1, r1, busy1, s0, r0, busy0, drop1, drop0);
            end
        end
        doReset();
    endtask

    task automatic test_single_set();
        logic expS;
        doReset();
        setIn = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            expS = (n == 6 || n == 7);
            assertCount++;
            if (s1 !== expS || busy1 !== expS || r1 !== 1'b0 || s0 !== expS) begin
                failCount++;
                $display("[TB] FAIL single_set edge k+%0d: got S=%b busy=%b R=%b S0=%b required S=busy=%b R=0",
                         n, s1, busy1, r1, s0, expS);
            end
        end
        assertCount++;
        if (drop1 !== 8'd0) begin
            failCount++;
            $display("[TB] FAIL single_set_drop: got %0d required 0", drop1);
        end
        setIn = 1'b0;
    endtask

    task automatic test_glitch();
        logic [7:0] pattern;
        pattern = 8'b01010111;
        doReset();
        for (int n = 0; n < 20; n++) begin
            setIn = (n < 8) ? pattern[n] : 1'b0;
            @(posedge clk);
            #1;
            assertCount++;
            if (s1 !== 1'b0 || busy1 !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL glitch n=%0d: got S=%b busy=%b required 0", n, s1, busy1);
            end
        end
        assertCount++;
        if (drop1 !== 8'd0) begin
            failCount++;
            $display("[TB] FAIL glitch_drop: got %0d required 0", drop1);
        end
    endtask

    task automatic test_conflict();
        logic expR;
        doReset();
        setIn = 1'b1;
        resetIn = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            expR = (n == 6 || n == 7);
            assertCount++;
            if (r1 !== expR || s1 !== 1'b0 || r0 !== 1'b0 || s0 !== 1'b0 || busy0 !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL conflict edge k+%0d: got R1=%b S1=%b R0=%b S0=%b busy0=%b required R1=%b others 0",
                         n, r1, s1, r0, s0, busy0, expR);
            end
        end
        assertCount++;
        if (drop1 !== 8'd1 || drop0 !== 8'd1) begin
            failCount++;
            $display("[TB] FAIL conflict_drop: got %0d/%0d required 1/1", drop1, drop0);
        end
        setIn = 1'b0;
        resetIn = 1'b0;
    endtask

    task automatic test_set_then_reset();
        logic expS;
        doReset();
        setIn = 1'b1;
        @(posedge clk);
        #1;
        resetIn = 1'b1;
        for (int n = 1; n < 20; n++) begin
            @(posedge clk);
            #1;
            expS = (n == 6 || n == 7);
            assertCount++;
            if (s1 !== expS || r1 !== 1'b0 || s0 !== expS || r0 !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL set_then_reset edge k+%0d: got S1=%b R1=%b S0=%b R0=%b required S=%b R=0",
                         n, s1, r1, s0, r0, expS);
            end
        end
        assertCount++;
        if (drop1 !== 8'd1 || drop0 !== 8'd1) begin
            failCount++;
            $display("[TB] FAIL set_then_reset_drop: got %0d/%0d required 1/1", drop1, drop0);
        end
        setIn = 1'b0;
        resetIn = 1'b0;
    endtask

    task automatic test_async_reset_and_saturation();
        logic expS;
        doReset();
        setIn = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        assertCount++;
        if (s1 !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL pre_reset_pulse: got S=%b required 1", s1);
        end
        #3;
        rst = 1'b1;
        #1;
        assertCount++;
        if (s1 !== 1'b0 || busy1 !== 1'b0 || drop1 !== 8'd0) begin
            failCount++;
            $display("[TB] FAIL async_reset: got S=%b busy=%b drop=%0d required 0/0/0", s1, busy1, drop1);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            expS = (n == 6 || n == 7);
            assertCount++;
            if (s1 !== expS || busy1 !== expS) begin
                failCount++;
                $display("[TB] FAIL post_reset edge j+%0d: got S=%b busy=%b required %b", n, s1, busy1, expS);
            end
        end
        setIn = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        for (int i = 0; i < 300; i++) begin
            setIn = 1'b1;
            resetIn = 1'b1;
            repeat (8) @(posedge clk);
            #1;
            setIn = 1'b0;
            resetIn = 1'b0;
            repeat (8) @(posedge clk);
            #1;
            if (i == 9 || i == 254) begin
                assertCount++;
                if (drop1 !== 8'(i + 1) || drop0 !== 8'(i + 1)) begin
                    failCount++;
                    $display("[TB] FAIL drop_count after %0d conflicts: got %0d/%0d required %0d",
                             i + 1, drop1, drop0, i + 1);
                end
            end
        end
        assertCount++;
        if (drop1 !== 8'd255 || drop0 !== 8'd255) begin
            failCount++;
            $display("[TB] FAIL drop_saturate: got %0d/%0d required 255/255", drop1, drop0);
        end
    endtask

    initial begin
        test_reset();
        test_single_set();
        test_glitch();
        test_conflict();
        test_set_then_reset();
        test_async_reset_and_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
